// File: rtl/sum_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sum_serializer
// Function : Captures an adder sum on LOAD and shifts it out serially with
//            valid/done framing; optional even-parity bit when the macro
//            SUM_SERIALIZER_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sum_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             svalid,
    output logic             done,
    output logic             ovr
);

    localparam int              c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_fin   = 2'd3;
`ifdef SUM_SERIALIZER_PARITY_EN
    localparam logic [1:0] c_par   = 2'd2;
    localparam logic [1:0] c_after = c_par;
`else
    localparam logic [1:0] c_after = c_fin;
`endif

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_load_q;
    logic               r_ready;
    logic               r_sout;
    logic               r_svalid;
    logic               r_done;
    logic               r_ovr;

    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shreg_shift;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_head;
    logic               w_sout_nxt;
`ifdef SUM_SERIALIZER_PARITY_EN
    logic               r_par;
    logic               w_par_nxt;
`endif

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shreg_shift = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_head        = w_shreg_nxt[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shreg_shift = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_head        = w_shreg_nxt[0];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
`ifdef SUM_SERIALIZER_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            c_idle, c_fin: begin
                if (load) begin
                    w_state_nxt = c_shift;
                    w_shreg_nxt = d;
                    w_cnt_nxt   = '0;
`ifdef SUM_SERIALIZER_PARITY_EN
                    w_par_nxt   = ^d;
`endif
                end else begin
                    w_state_nxt = c_idle;
                end
            end
            c_shift: begin
                w_shreg_nxt = w_shreg_shift;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    w_state_nxt = c_after;
                end
            end
`ifdef SUM_SERIALIZER_PARITY_EN
            c_par: begin
                w_state_nxt = c_fin;
            end
`endif
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Serial bit for the coming cycle, so SOUT leaves a flop directly.
    always_comb begin
        w_sout_nxt = 1'b0;
        if (w_state_nxt == c_shift) begin
            w_sout_nxt = w_head;
        end
`ifdef SUM_SERIALIZER_PARITY_EN
        else if (w_state_nxt == c_par) begin
            w_sout_nxt = w_par_nxt;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_load_q <= 1'b0;
            r_ready  <= 1'b1;
            r_sout   <= 1'b0;
            r_svalid <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
`ifdef SUM_SERIALIZER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_load_q <= load;
            r_ready  <= (w_state_nxt == c_idle) || (w_state_nxt == c_fin);
            r_svalid <= (w_state_nxt != c_idle) && (w_state_nxt != c_fin);
            r_done   <= (w_state_nxt == c_fin);
            r_sout   <= w_sout_nxt;
`ifdef SUM_SERIALIZER_PARITY_EN
            r_par    <= w_par_nxt;
`endif
            // Only a fresh LOAD request counts as overrun; a LOAD held high
            // across back-to-back frames is a continuing request.
            if (load && !r_ready && !r_load_q) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign ready  = r_ready;
    assign sout   = r_sout;
    assign svalid = r_svalid;
    assign done   = r_done;
    assign ovr    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sum_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_serializer
// Function : Self-checking bench for sum_serializer (MSB- and LSB-first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_serializer;

    localparam int W = 8;
`ifdef SUM_SERIALIZER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] d     = '0;
    logic ready_m, sout_m, svalid_m, done_m, ovr_m;
    logic ready_l, sout_l, svalid_l, done_l, ovr_l;

    sum_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .d(d), .load(load),
        .ready(ready_m), .sout(sout_m), .svalid(svalid_m), .done(done_m), .ovr(ovr_m)
    );
    sum_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .d(d), .load(load),
        .ready(ready_l), .sout(sout_l), .svalid(svalid_l), .done(done_l), .ovr(ovr_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic [W-1:0] dv;
        logic [4:0]   exp;   // {ready, svalid, sout, done, ovr}
    } vec_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  q_m[$];
    bit  q_l[$];
    bit  m_done = 0;
    bit  m_ovr  = 0;
    bit  m_prev = 0;
    logic [31:0] col_bits;
    int  col_n;
    int  done_seen;

    function automatic logic [4:0] outs_m();
        return {ready_m, svalid_m, sout_m, done_m, ovr_m};
    endfunction
    function automatic logic [4:0] outs_l();
        return {ready_l, svalid_l, sout_l, done_l, ovr_l};
    endfunction

    // Expected transmitted frame (MSB-first order) as an integer value.
    function automatic logic [31:0] fr(input logic [W-1:0] v);
        logic [31:0] r;
        r = {24'd0, v};
        if (PB != 0) r = {r[30:0], ^v};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        q_m.delete();
        q_l.delete();
        m_done = 0;
        m_ovr  = 0;
        m_prev = 0;
    endfunction

    // Reference: a frame is a queue of pending bits; outputs follow its occupancy.
    function automatic logic [4:0] model_exp(input bit busy, input bit head);
        return {!busy, busy, busy & head, !busy & m_done, m_ovr};
    endfunction

    function automatic void model_edge(input logic ld, input logic [W-1:0] dv);
        if (q_m.size() > 0) begin
            if (ld && !m_prev) m_ovr = 1;
            void'(q_m.pop_front());
            void'(q_l.pop_front());
            m_done = (q_m.size() == 0);
        end else begin
            m_done = 0;
            if (ld) begin
                for (int i = 0; i < W; i++) begin
                    q_m.push_back(dv[W-1-i]);
                    q_l.push_back(dv[i]);
                end
                if (PB != 0) begin
                    q_m.push_back(^dv);
                    q_l.push_back(^dv);
                end
            end
        end
        m_prev = ld;
    endfunction

    task automatic step(input logic ld, input logic [W-1:0] dv);
        bit bm, bl;
        load = ld;
        d    = dv;
        @(negedge clk);
        bm = (q_m.size() > 0);
        bl = (q_l.size() > 0);
        check("model_msb", outs_m(), model_exp(bm, bm ? q_m[0] : 1'b0));
        check("model_lsb", outs_l(), model_exp(bl, bl ? q_l[0] : 1'b0));
        if (svalid_m) begin
            col_bits = {col_bits[30:0], sout_m};
            col_n++;
        end
        if (done_m) done_seen++;
        @(posedge clk);
        model_edge(ld, dv);
        #1;
    endtask

    task automatic async_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_msb"}, outs_m(), 5'b10000);
        check({name, "_lsb"}, outs_l(), 5'b10000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic col_clear();
        col_bits  = '0;
        col_n     = 0;
        done_seen = 0;
    endtask

    vec_t tbl[$];

    initial begin
        // Directed A5 frame; palindrome, so both bit orders expect the same stream.
        tbl.push_back('{1'b1, 8'hA5, 5'b10000});
        tbl.push_back('{1'b0, 8'h00, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 5'b01000});
        tbl.push_back('{1'b0, 8'h00, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 5'b01000});
        tbl.push_back('{1'b0, 8'h00, 5'b01000});
        tbl.push_back('{1'b0, 8'h00, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 5'b01000});
        tbl.push_back('{1'b0, 8'h00, 5'b01100});
`ifdef SUM_SERIALIZER_PARITY_EN
        tbl.push_back('{1'b0, 8'h00, 5'b01000});
`endif
        tbl.push_back('{1'b0, 8'h00, 5'b10010});
        tbl.push_back('{1'b0, 8'h00, 5'b10000});

        // Reset held with LOAD active.
        rst_n = 1'b0;
        load  = 1'b1;
        d     = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_msb", outs_m(), 5'b10000);
            check("reset_lsb", outs_l(), 5'b10000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load  = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            load = tbl[i].ld;
            d    = tbl[i].dv;
            @(negedge clk);
            check($sformatf("tbl%0d_msb", i), outs_m(), tbl[i].exp);
            check($sformatf("tbl%0d_lsb", i), outs_l(), tbl[i].exp);
            @(posedge clk);
            model_edge(tbl[i].ld, tbl[i].dv);
            #1;
        end

        // Back-to-back frames with LOAD held high.
        col_clear();
        step(1'b1, 8'h0F);
        repeat (W + PB + 1) step(1'b1, 8'hF0);
        repeat (W + PB + 2) step(1'b0, 8'h00);
        check("b2b_bits", col_bits, (fr(8'h0F) << (W + PB)) | fr(8'hF0));
        check("b2b_count", col_n, 2 * (W + PB));
        check("b2b_done", done_seen, 2);
        check("b2b_ovr", ovr_m, 1'b0);

        // LOAD pulse during the third bit: frame unaffected, OVR sticky.
        col_clear();
        step(1'b1, 8'h3C);
        step(1'b0, 8'h3C);
        step(1'b0, 8'h3C);
        step(1'b1, 8'hFF);
        repeat (W + PB + 3) step(1'b0, 8'h00);
        check("ovr_bits", col_bits, fr(8'h3C));
        check("ovr_set_msb", ovr_m, 1'b1);
        check("ovr_set_lsb", ovr_l, 1'b1);
        step(1'b1, 8'h55);
        repeat (W + PB + 2) step(1'b0, 8'h00);
        check("ovr_sticky", ovr_m, 1'b1);

        // Reset during the fifth bit, then a clean frame.
        async_reset("rst_clr");
        col_clear();
        step(1'b1, 8'h81);
        repeat (4) step(1'b0, 8'h00);
        #2;
        async_reset("rst_mid");
        repeat (3) step(1'b0, 8'h00);
        check("rst_no_done", done_seen, 0);
        col_clear();
        step(1'b1, 8'h01);
        repeat (W + PB + 2) step(1'b0, 8'h00);
        check("rst_clean_bits", col_bits, fr(8'h01));
        check("rst_clean_done", done_seen, 1);
        check("rst_clean_ovr", ovr_m, 1'b0);

        // Randomised traffic against the frame-queue model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                #2;
                async_reset("rst_rand");
            end else begin
                step(($urandom_range(0, 2) == 0), W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
